// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and FSM state encoding for the cache memory
// responder and its latency counter.
//   ADDR_W : word address width, {tag, index}
//   DATA_W : backing word width
//   TAG_W  : tag field width (upper address bits)
//   IDX_W  : index field width (lower address bits)
//   CNT_W  : latency counter width, covers LATENCY up to 15
package cache_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int TAG_W  = 3;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cache_lat_counter.sv
// cache_lat_counter: loadable down-counter with a terminal-count (zero) flag.
// Ports:
//   clock      : sole clock, rising edge
//   reset_n    : asynchronous active-low reset, clears the count
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module cache_lat_counter
  import cache_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: backing-memory model answering cache fill reads and
// write-backs after a fixed latency.
//
// State table
//   state   | meaning
//   IDLE    | ready for a request; req_ready=1
//   BUSY    | latency countdown; array access on the BUSY->RESP edge
//   RESP    | one-cycle resp_valid pulse, then back to IDLE
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req_valid/req_ready : request handshake, accepted when both high
//   req_write      : 1 = write-back, 0 = fill read
//   req_addr       : {tag[2:0], index[1:0]}
//   req_wdata      : write-back data
//   resp_valid     : one-cycle completion pulse
//   resp_rdata     : fill data, holds its last value between reads
//
// Build option CACHE_MEM_WBUF_EN: posts writes into a one-entry buffer that
// answers on the next cycle and drains to the array LATENCY cycles later.
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] read_val;

  logic accept;
  logic complete;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic ready;

  cache_lat_counter u_lat_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef CACHE_MEM_WBUF_EN
  logic              wbuf_valid_q;
  logic [ADDR_W-1:0] wbuf_addr_q;
  logic [DATA_W-1:0] wbuf_data_q;
  logic              wbuf_load;
  logic              wbuf_drain;
  logic              drain_zero;

  // The drain timer runs independently of the FSM so reads can proceed
  // while a posted write is still pending.
  cache_lat_counter u_drain_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (wbuf_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (wbuf_valid_q && !drain_zero),
    .zero_o     (drain_zero)
  );

  assign wbuf_drain = wbuf_valid_q && drain_zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
    end else if (wbuf_load) begin
      wbuf_valid_q <= 1'b1;
      wbuf_addr_q  <= req_addr;
      wbuf_data_q  <= req_wdata;
    end else if (wbuf_drain) begin
      wbuf_valid_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
`ifdef CACHE_MEM_WBUF_EN
    wbuf_load  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef CACHE_MEM_WBUF_EN
        // A second write must wait for the single buffer entry to drain.
        ready = !(wbuf_valid_q && req_write);
`else
        ready = 1'b1;
`endif
        if (req_valid && ready) begin
          accept = 1'b1;
`ifdef CACHE_MEM_WBUF_EN
          if (req_write) begin
            wbuf_load = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_BUSY;
          end
`else
          cnt_load = 1'b1;
          state_d  = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          complete = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    read_val = mem_q[addr_q];
`ifdef CACHE_MEM_WBUF_EN
    // Pending posted write is newer than the array contents.
    if (wbuf_valid_q && (wbuf_addr_q == addr_q)) begin
      read_val = wbuf_data_q;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      if (complete) begin
        if (wr_q) begin
          mem_q[addr_q] <= wdata_q;
        end else begin
          rdata_q <= read_val;
        end
      end
`ifdef CACHE_MEM_WBUF_EN
      if (wbuf_drain) begin
        mem_q[wbuf_addr_q] <= wbuf_data_q;
      end
`endif
    end
  end

  assign resp_rdata = rdata_q;

endmodule
